// File: rtl/arb_pkg.sv
// Shared types and width helper for the round-robin resource arbiter.
package arb_pkg;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    // Ceil-log2 with a floor of one bit, so degenerate counts still get a real vector.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set mask bit at or after ptr, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    int pos;

    // Walk from the farthest slot back to ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos > N - 1) pos = pos - N;
            if (mask[pos[IDW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Locking round-robin arbiter for one shared resource with an optional hold timeout.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           any_req
);

    localparam int             HCW  = clog2(MAX_HOLD + 1);
    localparam logic [IDW-1:0] LAST = IDW'(N - 1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;
    logic [N-1:0]   pick_mask;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           owner_req;
    logic           timeout;

    assign any_req   = |req;
    assign owner_req = |(req & gnt);
    // >= rather than == so a requester arriving after the counter saturated still gets served.
    assign timeout   = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD - 1);
    assign pick_mask = (state == OWNED) ? (req & ~gnt) : req;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .mask  (pick_mask),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= OWNED;
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        gnt_vld  <= 1'b1;
                        gnt_id   <= pick_idx;
                        ptr      <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
                        hold_cnt <= '0;
                    end
                end
                OWNED: begin
                    if ((!owner_req || timeout) && pick_found) begin
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        gnt_vld  <= 1'b1;
                        gnt_id   <= pick_idx;
                        ptr      <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
                        hold_cnt <= '0;
                    end else if (!owner_req) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_vld  <= 1'b0;
                        gnt_id   <= '0;
                        hold_cnt <= '0;
                    end else if (int'(hold_cnt) < MAX_HOLD) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Three arbiter instances (N4/16, N4/4, N3/16) checked per cycle against a queue-free model.
module tb_rr_resource_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_t, rst_w;
    logic [3:0] req_a, req_t;
    logic [2:0] req_w;
    logic [3:0] gnt_a, gnt_t;
    logic [2:0] gnt_w;
    logic       vld_a, vld_t, vld_w;
    logic       any_a, any_t, any_w;
    logic [1:0] id_a, id_t, id_w;

    rr_resource_arbiter #(.N(4), .MAX_HOLD(16)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .gnt(gnt_a),
        .gnt_vld(vld_a), .gnt_id(id_a), .any_req(any_a));
    rr_resource_arbiter #(.N(4), .MAX_HOLD(4)) dut_t (
        .clk(clk), .rst(rst_t), .req(req_t), .gnt(gnt_t),
        .gnt_vld(vld_t), .gnt_id(id_t), .any_req(any_t));
    rr_resource_arbiter #(.N(3), .MAX_HOLD(16)) dut_w (
        .clk(clk), .rst(rst_w), .req(req_w), .gnt(gnt_w),
        .gnt_vld(vld_w), .gnt_id(id_w), .any_req(any_w));

    int n_pass = 0;
    int n_total = 0;

    // Model: owner (-1 idle), next-search start, cycles the owner has held the grant.
    int m_owner[3];
    int m_ptr[3];
    int m_cyc[3];
    int m_n[3]   = '{4, 4, 3};
    int m_max[3] = '{16, 4, 16};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int pick(input int u, input logic [3:0] r, input int excl);
        for (int k = 0; k < m_n[u]; k++) begin
            int i;
            i = (m_ptr[u] + k) % m_n[u];
            if (r[i[1:0]] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic void step(input int u, input logic rs, input logic [3:0] r);
        int w;
        if (rs) begin
            m_owner[u] = -1;
            m_ptr[u]   = 0;
            m_cyc[u]   = 0;
            return;
        end
        w = -2;
        if (m_owner[u] < 0) w = pick(u, r, -1);
        else if (!r[m_owner[u]]) w = pick(u, r, m_owner[u]);
        else if (m_max[u] != 0 && m_cyc[u] >= m_max[u]) begin
            w = pick(u, r, m_owner[u]);
            if (w < 0) w = -2;
        end
        if (w == -2) m_cyc[u]++;
        else if (w == -1) begin
            m_owner[u] = -1;
            m_cyc[u]   = 0;
        end else begin
            m_owner[u] = w;
            m_ptr[u]   = (w + 1) % m_n[u];
            m_cyc[u]   = 1;
        end
    endfunction

    task automatic cmp_unit(input int u, input logic [3:0] g, input logic v,
                            input logic [1:0] id, input logic an, input logic [3:0] r);
        logic [3:0] eg;
        eg = (m_owner[u] < 0) ? 4'b0000 : 4'(1 << m_owner[u]);
        chk($sformatf("u%0d_gnt", u), {28'd0, g}, {28'd0, eg});
        chk($sformatf("u%0d_vld", u), {31'd0, v}, {31'd0, m_owner[u] >= 0});
        chk($sformatf("u%0d_id", u), {30'd0, id}, (m_owner[u] < 0) ? 0 : m_owner[u]);
        chk($sformatf("u%0d_any", u), {31'd0, an}, {31'd0, |r});
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        step(0, rst_a, req_a);
        step(1, rst_t, req_t);
        step(2, rst_w, {1'b0, req_w});
        @(negedge clk);
        cmp_unit(0, gnt_a, vld_a, id_a, any_a, req_a);
        cmp_unit(1, gnt_t, vld_t, id_t, any_t, req_t);
        cmp_unit(2, {1'b0, gnt_w}, vld_w, id_w, any_w, {1'b0, req_w});
    endtask

    int order[5] = '{0, 1, 2, 3, 0};
    int n_own;

    initial begin
        rst_a = 1'b1; rst_t = 1'b1; rst_w = 1'b1;
        req_a = 4'b1111; req_t = 4'b0000; req_w = 3'b000;

        // Reset held two edges with all requests high.
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_gnt", {28'd0, gnt_a}, 32'h0);
            chk("rst_vld", {31'd0, vld_a}, 32'h0);
            chk("rst_id", {30'd0, id_a}, 32'h0);
        end

        // Single requester, release, then pointer sits just past it.
        rst_a = 1'b0; rst_t = 1'b0; rst_w = 1'b0;
        req_a = 4'b0100;
        tick();
        chk("single_gnt", {28'd0, gnt_a}, 32'h4);
        chk("single_id", {30'd0, id_a}, 32'd2);
        tick();
        req_a = 4'b0000;
        tick();
        chk("release_gnt", {28'd0, gnt_a}, 32'h0);
        req_a = 4'b1111;
        tick();
        chk("ptr3_gnt", {28'd0, gnt_a}, 32'h8);

        // Fairness: each owner holds three cycles, then drops and re-raises.
        rst_a = 1'b1; req_a = 4'b0000;
        tick();
        rst_a = 1'b0; req_a = 4'b1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            chk("fair_gnt", {28'd0, gnt_a}, 32'(1 << order[s]));
            tick();
            tick();
            req_a[order[s]] = 1'b0;
            tick();
            chk("fair_nobubble", {31'd0, vld_a}, 32'd1);
            req_a[order[s]] = 1'b1;
        end

        // Reset in the middle of a grant, then pointer restarts at 0.
        rst_a = 1'b1; req_a = 4'b0000;
        tick();
        rst_a = 1'b0; req_a = 4'b0010;
        tick();
        chk("midrst_pre", {28'd0, gnt_a}, 32'h2);
        rst_a = 1'b1;
        tick();
        chk("midrst_gnt", {28'd0, gnt_a}, 32'h0);
        rst_a = 1'b0; req_a = 4'b0011;
        tick();
        chk("midrst_after", {28'd0, gnt_a}, 32'h1);
        req_a = 4'b0000;
        tick();

        // Hold timeout with MAX_HOLD=4.
        req_t = 4'b0011;
        tick();
        chk("to_first", {28'd0, gnt_t}, 32'h1);
        n_own = 1;
        for (int k = 0; k < 20 && gnt_t == 4'b0001; k++) begin
            tick();
            if (gnt_t == 4'b0001) n_own++;
        end
        chk("to_cycles", n_own, 32'd4);
        chk("to_next", {28'd0, gnt_t}, 32'h2);
        req_t = 4'b0000;
        tick();
        req_t = 4'b0001;
        tick();
        repeat (100) tick();
        chk("to_alone", {28'd0, gnt_t}, 32'h1);
        req_t = 4'b0000;
        tick();

        // N=3 wrap and re-raise ordering.
        req_w = 3'b100;
        tick();
        chk("wrap_own2", {29'd0, gnt_w}, 32'h4);
        req_w = 3'b011;
        tick();
        chk("wrap_gnt", {29'd0, gnt_w}, 32'h1);
        chk("wrap_id", {30'd0, id_w}, 32'd0);
        req_w = 3'b110;
        tick();
        chk("w_hand1", {29'd0, gnt_w}, 32'h2);
        req_w = 3'b111;
        tick();
        chk("w_wait", {29'd0, gnt_w}, 32'h2);
        req_w = 3'b101;
        tick();
        chk("w_hand2", {29'd0, gnt_w}, 32'h4);
        req_w = 3'b011;
        tick();
        chk("w_rerais", {29'd0, gnt_w}, 32'h1);
        req_w = 3'b000;
        tick();
        chk("w_idle", {29'd0, gnt_w}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
